// File: rtl/mmix_mem_arbiter.sv
// mmix_mem_arbiter
//   Shares one memory port between instruction fetch (F) and the exec_unit
//   data port (E). Both sides use a level request held until a one-cycle
//   done. E has priority; e_lock keeps F off the port across a multi-access
//   SAVE/UNSAVE sequence. A watchdog ends an access whose mem_done never
//   arrives, returning zero data and pulsing err.
//
//   Optional: `define MEMARB_ROUND_ROBIN_EN makes simultaneous F/E requests
//   alternate (last served loses the tie; E wins the first tie after reset).
//
// Parameters
//   WATCHDOG      max BUSY cycles waiting for mem_done (0 disables)
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   f_address/f_read             fetch request (always a tetra read)
//   f_readdata/f_done            fetch response, done is one cycle
//   e_address/e_datasize         exec request address and size
//   e_read/e_write/e_writedata   exec request; write wins if both set
//   e_lock                       keep F off the port between E accesses
//   e_readdata/e_done            exec response, done is one cycle
//   mem_*                        registered request to memory, mem_done/
//                                mem_readdata back from memory
//   grant                        bit0 F owns port, bit1 E owns port
//   err                          one-cycle pulse on watchdog expiry
module mmix_mem_arbiter #(
    parameter int unsigned WATCHDOG = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [63:0] f_address,
    input  logic        f_read,
    output logic [63:0] f_readdata,
    output logic        f_done,
    input  logic [63:0] e_address,
    input  logic [1:0]  e_datasize,
    input  logic        e_read,
    input  logic        e_write,
    input  logic [63:0] e_writedata,
    input  logic        e_lock,
    output logic [63:0] e_readdata,
    output logic        e_done,
    output logic [63:0] mem_address,
    output logic [1:0]  mem_datasize,
    output logic        mem_read,
    output logic        mem_write,
    output logic [63:0] mem_writedata,
    input  logic [63:0] mem_readdata,
    input  logic        mem_done,
    output logic [1:0]  grant,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, BUSY_F, BUSY_E, TURN} state_t;

    state_t      state, state_nx;
    logic [63:0] addr_nx, wdata_nx;
    logic [1:0]  size_nx, grant_nx;
    logic        rd_nx, wr_nx;
    logic [31:0] wd_cnt, wd_cnt_nx;
    logic        busy, expire, e_req, f_ok, pick_e;
`ifdef MEMARB_ROUND_ROBIN_EN
    logic        last_e, last_e_nx;
`endif

    function automatic logic [63:0] align_addr(input logic [63:0] a, input logic [1:0] sz);
        logic [63:0] r;
        r = a;
        case (sz)
            2'd1:    r = {a[63:1], 1'b0};
            2'd2:    r = {a[63:2], 2'b0};
            2'd3:    r = {a[63:3], 3'b0};
            default: r = a;
        endcase
        return r;
    endfunction

    assign busy  = (state == BUSY_F) || (state == BUSY_E);
    // mem_done arriving in the expiry cycle wins: it is a normal completion
    assign expire = (WATCHDOG != 0) && busy && (wd_cnt == WATCHDOG - 1) && !mem_done;
    assign e_req = e_read | e_write;
    assign f_ok  = f_read & ~e_lock;
`ifdef MEMARB_ROUND_ROBIN_EN
    // on a tie, E yields only if it was the last one served
    assign pick_e = e_req & ~(f_ok & last_e);
`else
    assign pick_e = e_req;
`endif

    always_comb begin
        state_nx   = state;
        addr_nx    = mem_address;
        size_nx    = mem_datasize;
        rd_nx      = mem_read;
        wr_nx      = mem_write;
        wdata_nx   = mem_writedata;
        grant_nx   = grant;
        wd_cnt_nx  = wd_cnt;
`ifdef MEMARB_ROUND_ROBIN_EN
        last_e_nx  = last_e;
`endif
        f_done     = 1'b0;
        e_done     = 1'b0;
        f_readdata = '0;
        e_readdata = '0;
        err        = 1'b0;
        case (state)
            IDLE: begin
                if (pick_e) begin
                    state_nx  = BUSY_E;
                    addr_nx   = align_addr(e_address, e_datasize);
                    size_nx   = e_datasize;
                    rd_nx     = e_read & ~e_write;
                    wr_nx     = e_write;
                    wdata_nx  = e_writedata;
                    grant_nx  = 2'b10;
                    wd_cnt_nx = '0;
`ifdef MEMARB_ROUND_ROBIN_EN
                    last_e_nx = 1'b1;
`endif
                end else if (f_ok) begin
                    state_nx  = BUSY_F;
                    addr_nx   = align_addr(f_address, 2'd2);
                    size_nx   = 2'd2;
                    rd_nx     = 1'b1;
                    wr_nx     = 1'b0;
                    grant_nx  = 2'b01;
                    wd_cnt_nx = '0;
`ifdef MEMARB_ROUND_ROBIN_EN
                    last_e_nx = 1'b0;
`endif
                end
            end
            BUSY_F, BUSY_E: begin
                wd_cnt_nx = wd_cnt + 32'd1;
                if (mem_done || expire) begin
                    if (state == BUSY_F) begin
                        f_done     = 1'b1;
                        f_readdata = mem_done ? mem_readdata : '0;
                    end else begin
                        e_done     = 1'b1;
                        e_readdata = mem_done ? mem_readdata : '0;
                    end
                    err      = expire;
                    state_nx = TURN;
                    rd_nx    = 1'b0;
                    wr_nx    = 1'b0;
                    grant_nx = '0;
                end
            end
            TURN:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            mem_address   <= '0;
            mem_datasize  <= '0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_writedata <= '0;
            grant         <= '0;
            wd_cnt        <= '0;
`ifdef MEMARB_ROUND_ROBIN_EN
            last_e        <= 1'b0;
`endif
        end else begin
            state         <= state_nx;
            mem_address   <= addr_nx;
            mem_datasize  <= size_nx;
            mem_read      <= rd_nx;
            mem_write     <= wr_nx;
            mem_writedata <= wdata_nx;
            grant         <= grant_nx;
            wd_cnt        <= wd_cnt_nx;
`ifdef MEMARB_ROUND_ROBIN_EN
            last_e        <= last_e_nx;
`endif
        end
    end

endmodule
